// File: rtl/imem_loader.sv
// imem_loader: byte-serial program loader for the RV32I core.
// Receives a framed image (16-bit word count, little-endian words,
// optional checksum byte), writes each word into instruction memory and
// holds the core in reset until the image is accepted.
// Optional feature macro: IMEM_LOADER_CSUM_EN (trailing XOR checksum byte).
module imem_loader #(
  parameter int DEPTH   = 64,
  parameter int TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        we,
  output logic [31:0] waddr,
  output logic [31:0] wdata,
  output logic        cpu_reset,
  output logic        done,
  output logic        err
);

  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

`ifdef IMEM_LOADER_CSUM_EN
  typedef enum logic [2:0] {HDR0, HDR1, DATA, CSUM, RUN, ERROR} state_t;
`else
  // DRAIN covers the cycle of the final write pulse so the core only
  // leaves reset after the last word has landed in memory.
  typedef enum logic [2:0] {HDR0, HDR1, DATA, DRAIN, RUN, ERROR} state_t;
`endif

  state_t state, state_next;

  logic [15:0]   n_words;
  logic [15:0]   word_idx;
  logic [1:0]    byte_cnt;
  logic [23:0]   asm_q;
  logic [IW-1:0] idle;
`ifdef IMEM_LOADER_CSUM_EN
  logic [7:0]    xsum;
`endif

  logic        xfer;
  logic        idle_state;
  logic        timeout;
  logic        last_word;
  logic [15:0] n_full;

`ifdef IMEM_LOADER_CSUM_EN
  assign rx_ready   = (state == HDR0) || (state == HDR1) || (state == DATA) || (state == CSUM);
  assign idle_state = (state == HDR1) || (state == DATA) || (state == CSUM);
`else
  assign rx_ready   = (state == HDR0) || (state == HDR1) || (state == DATA);
  assign idle_state = (state == HDR1) || (state == DATA);
`endif

  assign xfer      = rx_valid & rx_ready;
  assign n_full    = {rx_data, n_words[7:0]};
  assign timeout   = idle_state && !xfer && (idle == IW'(TIMEOUT - 1));
  assign last_word = (byte_cnt == 2'd3) && (word_idx == n_words - 16'd1);

  // State register; reset drops straight back to waiting for a header.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= HDR0;
    end else begin
      state <= state_next;
    end
  end

  // Frame sequencing: header, payload words, optional checksum, then a terminal state.
  always_comb begin
    state_next = state;
    case (state)
      HDR0: begin
        if (xfer) state_next = HDR1;
      end
      HDR1: begin
        if (xfer) begin
          if (n_full > 16'(DEPTH)) begin
            state_next = ERROR;
          end else if (n_full == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
            state_next = CSUM;
`else
            state_next = RUN;
`endif
          end else begin
            state_next = DATA;
          end
        end else if (timeout) begin
          state_next = HDR0;
        end
      end
      DATA: begin
        if (xfer && last_word) begin
`ifdef IMEM_LOADER_CSUM_EN
          state_next = CSUM;
`else
          state_next = DRAIN;
`endif
        end else if (timeout) begin
          state_next = HDR0;
        end
      end
`ifdef IMEM_LOADER_CSUM_EN
      CSUM: begin
        if (xfer) begin
          state_next = (rx_data == xsum) ? RUN : ERROR;
        end else if (timeout) begin
          state_next = HDR0;
        end
      end
`else
      DRAIN: begin
        state_next = RUN;
      end
`endif
      RUN:     state_next = RUN;
      ERROR:   state_next = ERROR;
      default: state_next = HDR0;
    endcase
  end

  // Datapath: header capture, word assembly, memory writes, idle timer and status flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      n_words   <= '0;
      word_idx  <= '0;
      byte_cnt  <= '0;
      asm_q     <= '0;
      idle      <= '0;
`ifdef IMEM_LOADER_CSUM_EN
      xsum      <= '0;
`endif
      we        <= 1'b0;
      waddr     <= '0;
      wdata     <= '0;
      cpu_reset <= 1'b1;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      we        <= 1'b0;
      done      <= (state_next == RUN);
      err       <= (state_next == ERROR);
      cpu_reset <= (state_next != RUN);

      if (xfer || !idle_state || timeout) begin
        idle <= '0;
      end else begin
        idle <= idle + IW'(1);
      end

      if (timeout) begin
        word_idx <= '0;
        byte_cnt <= '0;
        asm_q    <= '0;
`ifdef IMEM_LOADER_CSUM_EN
        xsum     <= '0;
`endif
      end else if (xfer) begin
        case (state)
          HDR0: n_words[7:0]  <= rx_data;
          HDR1: n_words[15:8] <= rx_data;
          DATA: begin
            byte_cnt <= byte_cnt + 2'd1;
            asm_q    <= {rx_data, asm_q[23:8]};
`ifdef IMEM_LOADER_CSUM_EN
            xsum     <= xsum ^ rx_data;
`endif
            if (byte_cnt == 2'd3) begin
              we    <= 1'b1;
              waddr <= {14'd0, word_idx, 2'b00};
              wdata <= {rx_data, asm_q};
              if (!last_word) word_idx <= word_idx + 16'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: self-checking bench for imem_loader.
// Table vectors, directed multi-cycle sequences (release timing, timeout,
// reset mid-frame) and random frames against a frame-level reference model.
// Follows IMEM_LOADER_CSUM_EN the same way the design does.
module tb_imem_loader;

  localparam int DEPTH   = 64;
  localparam int TIMEOUT = 1023;
`ifdef IMEM_LOADER_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_ready;
  logic        we;
  logic [31:0] waddr;
  logic [31:0] wdata;
  logic        cpu_reset;
  logic        done;
  logic        err;

  int vecs = 0;
  int miss = 0;

  logic [63:0] cap_q[$];
  logic [63:0] exp_q[$];
  logic [7:0]  frame_q[$];
  logic [31:0] word_q[$];
  bit          exp_done;
  bit          exp_err;

  typedef struct {
    string       name;
    int          n;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  flip;
    int          exp_writes;
    bit          exp_done;
    bit          exp_err;
  } vec_t;

  vec_t tbl[5];

  imem_loader #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .cpu_reset (cpu_reset),
    .done      (done),
    .err       (err)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Record every memory write, sampled mid-cycle
  always @(negedge clk) begin
    if (reset && we) cap_q.push_back({waddr, wdata});
  end

  // Hard stop if the run ever stalls
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, summary not reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset;
    rx_valid = 1'b0;
    reset = 1'b0;
    #2;
    checkOutput("rst rx_ready", 32'(rx_ready), 32'd1);
    checkOutput("rst we", 32'(we), 32'd0);
    checkOutput("rst waddr", waddr, 32'd0);
    checkOutput("rst wdata", wdata, 32'd0);
    checkOutput("rst cpu_reset", 32'(cpu_reset), 32'd1);
    checkOutput("rst done", 32'(done), 32'd0);
    checkOutput("rst err", 32'(err), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    cap_q.delete();
  endtask

  task automatic build_frame(input int n, input logic [7:0] flip);
    logic [7:0]  x;
    logic [15:0] n16;
    x = 8'h00;
    n16 = n[15:0];
    frame_q.delete();
    frame_q.push_back(n16[7:0]);
    frame_q.push_back(n16[15:8]);
    foreach (word_q[i]) begin
      for (int b = 0; b < 4; b++) begin
        frame_q.push_back(word_q[i][8*b +: 8]);
        x = x ^ word_q[i][8*b +: 8];
      end
    end
`ifdef IMEM_LOADER_CSUM_EN
    frame_q.push_back(x ^ flip);
`else
    if (flip != 8'h00) x = x ^ flip;
`endif
  endtask

  task automatic run_model;
    int         n;
    logic [7:0] x;
    bit         complete;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    if (frame_q.size() < 2) return;
    n = int'({frame_q[1], frame_q[0]});
    if (n > DEPTH) begin
      exp_err = 1'b1;
      return;
    end
    x = 8'h00;
    complete = 1'b1;
    for (int w = 0; w < n; w++) begin
      int b;
      b = 2 + 4 * w;
      if (b + 3 >= frame_q.size()) begin
        complete = 1'b0;
        break;
      end
      exp_q.push_back({32'(w * 4), frame_q[b+3], frame_q[b+2], frame_q[b+1], frame_q[b]});
      x = x ^ frame_q[b] ^ frame_q[b+1] ^ frame_q[b+2] ^ frame_q[b+3];
    end
`ifdef IMEM_LOADER_CSUM_EN
    if (complete && frame_q.size() > 2 + 4 * n) begin
      exp_done = (frame_q[2 + 4 * n] == x);
      exp_err  = !exp_done;
    end
`else
    exp_done = complete;
`endif
  endtask

  task automatic applyStimulus(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      rx_valid = 1'b1;
      rx_data  = frame_q[i];
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic check_frame(input string tag);
    repeat (3) @(negedge clk);
    checkOutput({tag, " write count"}, 32'(cap_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < cap_q.size()) begin
        checkOutput({tag, " waddr"}, cap_q[i][63:32], exp_q[i][63:32]);
        checkOutput({tag, " wdata"}, cap_q[i][31:0], exp_q[i][31:0]);
      end
    end
    checkOutput({tag, " done"}, 32'(done), 32'(exp_done));
    checkOutput({tag, " err"}, 32'(err), 32'(exp_err));
    checkOutput({tag, " cpu_reset"}, 32'(cpu_reset), 32'(!exp_done));
    checkOutput({tag, " rx_ready"}, 32'(rx_ready), 32'(!(exp_done || exp_err)));
  endtask

  initial begin
    int          n;
    int          nw;
    int          sel;
    logic [7:0]  flip;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]  csum_b;
`endif

    tbl[0] = '{"n2 good",   2,  32'h00500093, 32'h00A00113, 8'h00, 2, 1'b1, 1'b0};
    tbl[1] = '{"n2 badsum", 2,  32'h00500093, 32'h00A00113, 8'h01, 2, !CSUM_ON, CSUM_ON};
    tbl[2] = '{"n65 over",  65, 32'h11111111, 32'h22222222, 8'h00, 0, 1'b0, 1'b1};
    tbl[3] = '{"n1 beef",   1,  32'hDEADBEEF, 32'h00000000, 8'h00, 1, 1'b1, 1'b0};
    tbl[4] = '{"n0 empty",  0,  32'h00000000, 32'h00000000, 8'h00, 0, 1'b1, 1'b0};

    #1;
    do_reset;

    // Table-driven frames with hand-derived expectations
    for (int t = 0; t < 5; t++) begin
      do_reset;
      word_q.delete();
      if (tbl[t].n >= 1) word_q.push_back(tbl[t].w0);
      if (tbl[t].n >= 2) word_q.push_back(tbl[t].w1);
      build_frame(tbl[t].n, tbl[t].flip);
      exp_q.delete();
      for (int i = 0; i < tbl[t].exp_writes; i++)
        exp_q.push_back({32'(i * 4), (i == 0) ? tbl[t].w0 : tbl[t].w1});
      exp_done = tbl[t].exp_done;
      exp_err  = tbl[t].exp_err;
      applyStimulus(0, frame_q.size());
      check_frame(tbl[t].name);
    end

    // Release timing around the final write
    do_reset;
    word_q.delete();
    word_q.push_back(32'hDEADBEEF);
    build_frame(1, 8'h00);
`ifdef IMEM_LOADER_CSUM_EN
    csum_b = frame_q.pop_back();
`endif
    applyStimulus(0, frame_q.size());
    checkOutput("rel we", 32'(we), 32'd1);
    checkOutput("rel waddr", waddr, 32'd0);
    checkOutput("rel wdata", wdata, 32'hDEADBEEF);
    checkOutput("rel cpu_reset held", 32'(cpu_reset), 32'd1);
    checkOutput("rel done early", 32'(done), 32'd0);
`ifdef IMEM_LOADER_CSUM_EN
    frame_q.delete();
    frame_q.push_back(csum_b);
    applyStimulus(0, 1);
`else
    @(negedge clk);
    checkOutput("rel we drop", 32'(we), 32'd0);
`endif
    checkOutput("rel cpu_reset", 32'(cpu_reset), 32'd0);
    checkOutput("rel done", 32'(done), 32'd1);
    checkOutput("rel rx_ready", 32'(rx_ready), 32'd0);

    // Stall one cycle short of the timeout: frame must still complete
    do_reset;
    word_q.delete();
    word_q.push_back(32'hCAFE0001);
    word_q.push_back(32'h12345678);
    build_frame(2, 8'h00);
    run_model;
    applyStimulus(0, 8);
    repeat (TIMEOUT - 1) @(negedge clk);
    applyStimulus(8, frame_q.size());
    check_frame("stall short");

    // Stall the full timeout: partial word dropped, resend loads from address 0
    do_reset;
    applyStimulus(0, 8);
    repeat (TIMEOUT) @(negedge clk);
    checkOutput("timeout writes", 32'(cap_q.size()), 32'd1);
    checkOutput("timeout rx_ready", 32'(rx_ready), 32'd1);
    checkOutput("timeout cpu_reset", 32'(cpu_reset), 32'd1);
    cap_q.delete();
    applyStimulus(0, frame_q.size());
    check_frame("timeout resend");

    // Reset in the middle of DATA, then a fresh single-word frame
    do_reset;
    applyStimulus(0, 11);
    do_reset;
    word_q.delete();
    word_q.push_back(32'h0badf00d);
    build_frame(1, 8'h00);
    run_model;
    applyStimulus(0, frame_q.size());
    check_frame("after midreset");

    // Random frames against the reference model
    for (int r = 0; r < 6; r++) begin
      do_reset;
      sel = $urandom_range(0, 9);
      if (sel == 0)      n = DEPTH;
      else if (sel == 1) n = $urandom_range(DEPTH + 1, 300);
      else               n = $urandom_range(0, 5);
      nw = (n > DEPTH) ? 3 : n;
      word_q.delete();
      for (int i = 0; i < nw; i++) word_q.push_back($urandom);
      flip = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
      build_frame(n, flip);
      run_model;
      applyStimulus(0, frame_q.size());
      check_frame("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Byte-serial program loader upstream of the single-cycle RV32I core. It receives a framed program image from a host byte stream and assembles little-endian 32-bit words. It writes them into instruction memory through a write port and holds the core in reset until the image has loaded and validated. On success it releases the core, which starts fetching at PC 0.

## Interface
- DEPTH, 64, instruction memory size in 32-bit words; maximum accepted word count.
- TIMEOUT, 1023, idle cycles allowed between bytes in a partially received frame before the frame is abandoned.
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-low reset.
- rx_valid  in  1  host byte available.
- rx_data  in  8  host byte.
- rx_ready  out  1  loader can accept a byte; a byte transfers on any edge with rx_valid & rx_ready.
- we  out  1  instruction memory write strobe, single-cycle pulse.
- waddr  out  32  byte address of the word being written (word index × 4).
- wdata  out  32  assembled instruction word.
- cpu_reset  out  1  active-high reset to the core; high while loading.
- done  out  1  image loaded and accepted; core running.
- err  out  1  frame rejected; sticky until reset.

## Operation
- Frame format: byte 0 is N[7:0], byte 1 is N[15:8], then N words of 4 bytes each (LSB first), then 1 checksum byte (see Configuration).
- FSM states: HDR0, HDR1, DATA, CSUM, RUN, ERROR.
  - HDR0: on transfer, latch N[7:0] and go to HDR1.
  - HDR1: on transfer, latch N[15:8].
    - N > DEPTH: go to ERROR.
    - N == 0: go to CSUM, or to RUN when the checksum is compiled out.
    - Otherwise go to DATA.
  - DATA: shift bytes into a 4-byte assembler. On the 4th byte, issue a write and increment the word index. After word N, go to CSUM, or to RUN when the checksum is compiled out.
  - CSUM: on transfer, compare the byte to the running XOR of all payload bytes (header excluded). Match goes to RUN; mismatch goes to ERROR.
  - RUN: rx_ready=0, done=1, cpu_reset=0. Terminal state.
  - ERROR: rx_ready=0, err=1, cpu_reset=1. Terminal state.
- rx_ready=1 in HDR0, HDR1, DATA and CSUM.
- Timeout:
  - An idle counter clears on every transfer and increments each cycle in HDR1, DATA or CSUM while no transfer occurs.
  - When it reaches TIMEOUT, the FSM returns to HDR0 and clears the word index, assembler, and XOR.
  - No write is issued for a partial word.
  - Words already written stay in memory.
  - HDR0 never times out.
- Address arithmetic: waddr = {word_index, 2'b00}, zero-extended. The word index is 16 bits wide and never exceeds DEPTH-1.

## Timing
- Reset values: rx_ready=1 (state HDR0), we=0, waddr=0, wdata=0, cpu_reset=1, done=0, err=0. All other state is cleared.
- Reset asserted mid-frame or in RUN/ERROR returns to HDR0 immediately. cpu_reset rises asynchronously with reset.
- Write latency: we is high exactly in the cycle after the edge that transfers the 4th byte of a word. waddr and wdata are valid in that same cycle and are registered outputs.
- Back-to-back bytes at 1 per cycle are sustained with no stalls, so rx_ready never deasserts mid-frame.
- Release timing:
  - cpu_reset falls and done rises on the edge that enters RUN.
  - With the checksum compiled out, RUN is entered on the edge that ends the final we pulse. The last write therefore completes before the core leaves reset.
- The ERROR→err and RUN→done outputs are registered and change on the entering edge.

## Configuration
- IMEM_LOADER_CSUM_EN defined: the CSUM state and XOR accumulator exist, and the frame carries the trailing checksum byte.
- Not defined: no checksum byte, no CSUM state, and err can assert only for N > DEPTH.

## Test plan
- N=2 with words 0x00500093 and 0x00A00113, checksum correct, 1 byte/cycle: expect we pulses at waddr 0x0 then 0x4 with those values, then cpu_reset=0 and done=1 one edge after the checksum transfer.
- Same frame with checksum XOR 0x01: expect no release, err=1, cpu_reset stays 1, and rx_ready=0 afterwards.
- Header N=65 with DEPTH=64: expect ERROR after the header's 2nd byte, no we pulses, and err=1.
- Stall 1023 cycles after the 2nd byte of word 1: expect return to HDR0 with no we for word 1. A full valid frame resent afterwards loads correctly from waddr 0.
- Assert reset mid-DATA: expect all outputs at reset values immediately. After release, a fresh N=1 frame loads and releases the core.
- Build with IMEM_LOADER_CSUM_EN undefined, N=1 word 0xDEADBEEF and no checksum byte: expect we at waddr 0, then cpu_reset falling on the next edge.
